maxpool_pingpong_buffer: RTL and testbench

//  Double-buffered (ping-pong) store for max-pooling results between the pooling

---
 rtl/maxpool_pkg.sv | 27 ++
 rtl/maxpool_bank_ram.sv | 27 ++
 rtl/maxpool_pingpong_buffer.sv | 120 ++++++++++++
 tb/tb_maxpool_pingpong_buffer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maxpool_pkg.sv
// Shared types and helpers for the max-pool ping-pong buffer.
// sat_add clamps a signed sum into a w-bit two's complement range.
package maxpool_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 10;

  typedef logic bank_idx_t;

  typedef enum logic {
    BANK_FREE = 1'b0,
    BANK_FULL = 1'b1
  } bank_state_e;

  function automatic int sat_add(input int a, input int b, input int w);
    int sum;
    int hi;
    int lo;
    sum = a + b;
    hi  = (1 << (w - 1)) - 1;
    lo  = -(1 << (w - 1));
    if (sum > hi) return hi;
    if (sum < lo) return lo;
    return sum;
  endfunction

endpackage

// File: rtl/maxpool_bank_ram.sv
// One buffer bank: N_CH write ports and a single registered read port.
// Lanes are applied in index order, so the highest lane wins a same-address collision.
module maxpool_bank_ram #(
  parameter int N_CH   = 3,
  parameter int DEPTH  = 507,
  parameter int IDX_W  = 9,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic [N_CH-1:0]          we,
  input  logic [N_CH*IDX_W-1:0]    waddr,
  input  logic [N_CH*DATA_W-1:0]   wdata,
  input  logic                     re,
  input  logic [IDX_W-1:0]         raddr,
  output logic [DATA_W-1:0]        rq
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (we[i]) mem[waddr[i*IDX_W +: IDX_W]] <= wdata[i*DATA_W +: DATA_W];
    end
    if (re) rq <= mem[raddr];
  end

endmodule

// File: rtl/maxpool_pingpong_buffer.sv
// Ping-pong store between the pooling stage and the next layer.
// state      | meaning
// BANK_FREE  | bank owned by the writer, being filled
// BANK_FULL  | bank complete, owned by the reader until rd_frame_end
module maxpool_pingpong_buffer
  import maxpool_pkg::*;
#(
  parameter int N_CH   = 3,
  parameter int DEPTH  = 507,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int OFFSET = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wen,
  input  logic [N_CH-1:0]          wmask,
  input  logic [N_CH*ADDR_W-1:0]   waddr,
  input  logic [N_CH*DATA_W-1:0]   wdata,
  input  logic                     wr_frame_end,
  output logic                     wr_ready,
  input  logic                     ren,
  input  logic [ADDR_W-1:0]        raddr,
  input  logic                     rd_frame_end,
  output logic                     rd_avail,
  output logic [DATA_W-1:0]        rdata,
  output logic                     rvalid,
  output logic                     err_oob,
  output logic                     err_wr_stall
);

  localparam int IDX_W = $clog2(DEPTH);

  bank_state_e bank_state_q [2];
  bank_state_e bank_state_d [2];
  bank_idx_t   wr_bank_q, rd_bank_q, rd_sel_q;
  logic        rd_zero_q;

  logic [N_CH-1:0]       lane_en, lane_oob, lane_commit;
  logic [N_CH*IDX_W-1:0] waddr_idx;
  logic                  wr_end_fire, rd_end_fire, rd_fire, rd_in_range;
  logic [DATA_W-1:0]     bank_rq [2];
  logic [DATA_W-1:0]     rd_word;

  assign wr_ready    = (bank_state_q[wr_bank_q] == BANK_FREE);
  assign rd_avail    = (bank_state_q[rd_bank_q] == BANK_FULL);
  assign wr_end_fire = wr_frame_end & wr_ready;
  assign rd_end_fire = rd_frame_end & rd_avail;
  assign rd_fire     = ren & rd_avail;
  assign rd_in_range = (int'(raddr) < DEPTH);

  always_comb begin
    lane_en   = '0;
    lane_oob  = '0;
    waddr_idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      lane_en[i]  = wen & wmask[i];
      lane_oob[i] = lane_en[i] & (int'(waddr[i*ADDR_W +: ADDR_W]) >= DEPTH);
      waddr_idx[i*IDX_W +: IDX_W] = waddr[i*ADDR_W +: IDX_W];
    end
    lane_commit = lane_en & ~lane_oob & {N_CH{wr_ready}};
  end

  // The two flag updates never target the same bank, so applying both is safe.
  always_comb begin
    bank_state_d = bank_state_q;
    if (wr_end_fire) bank_state_d[wr_bank_q] = BANK_FULL;
    if (rd_end_fire) bank_state_d[rd_bank_q] = BANK_FREE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_state_q[0] <= BANK_FREE;
      bank_state_q[1] <= BANK_FREE;
      wr_bank_q       <= 1'b0;
      rd_bank_q       <= 1'b0;
      rd_sel_q        <= 1'b0;
      rd_zero_q       <= 1'b1;
      rvalid          <= 1'b0;
      err_oob         <= 1'b0;
      err_wr_stall    <= 1'b0;
    end else begin
      bank_state_q <= bank_state_d;
      if (wr_end_fire) wr_bank_q <= ~wr_bank_q;
      if (rd_end_fire) rd_bank_q <= ~rd_bank_q;
      rvalid <= rd_fire;
      if (rd_fire) begin
        rd_zero_q <= ~rd_in_range;
        rd_sel_q  <= rd_bank_q;
      end
      err_oob      <= err_oob | (|lane_oob);
      err_wr_stall <= err_wr_stall | ((wen | wr_frame_end) & ~wr_ready);
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    maxpool_bank_ram #(
      .N_CH  (N_CH),
      .DEPTH (DEPTH),
      .IDX_W (IDX_W),
      .DATA_W(DATA_W)
    ) u_ram (
      .clk  (clk),
      .we   (lane_commit & {N_CH{wr_bank_q == 1'(b)}}),
      .waddr(waddr_idx),
      .wdata(wdata),
      .re   (rd_fire & rd_in_range & (rd_bank_q == 1'(b))),
      .raddr(raddr[IDX_W-1:0]),
      .rq   (bank_rq[b])
    );
  end

  // rdata holds between reads because the RAM output register only loads on an accepted read.
  always_comb begin
    rd_word = bank_rq[rd_sel_q];
    rdata   = '0;
    if (!rd_zero_q) rdata = DATA_W'(sat_add(int'(signed'(rd_word)), OFFSET, DATA_W));
  end

endmodule

// File: tb/tb_maxpool_pingpong_buffer.sv
// Scoreboard bench: two DUT copies (offset +1 and -1) share stimulus and are
// compared against a frame/bank ownership model of the buffer.
module tb_maxpool_pingpong_buffer;

  localparam int N_CH   = 3;
  localparam int DEPTH  = 507;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;
  localparam int UNK    = 2147483647;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wen = 1'b0;
  logic [N_CH-1:0] wmask = '0;
  logic [N_CH*ADDR_W-1:0] waddr = '0;
  logic [N_CH*DATA_W-1:0] wdata = '0;
  logic wr_frame_end = 1'b0;
  logic ren = 1'b0;
  logic [ADDR_W-1:0] raddr = '0;
  logic rd_frame_end = 1'b0;

  logic              wr_ready_o [2];
  logic              rd_avail_o [2];
  logic [DATA_W-1:0] rdata_o    [2];
  logic              rvalid_o   [2];
  logic              err_oob_o  [2];
  logic              err_stall_o[2];

  int tests = 0;
  int fails = 0;
  int offs [2] = '{1, -1};

  int q0[$];
  int q1[$];
  logic exp_rv = 1'b0;
  int last_v [2] = '{0, 0};

  int mem_m [2][DEPTH];
  bit written [2][DEPTH];
  bit full_m [2];
  int wb_m = 0, rb_m = 0;
  bit eoob_m = 0, estall_m = 0;

  always #5 clk = ~clk;

  maxpool_pingpong_buffer #(.N_CH(N_CH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .OFFSET(1)) u_dut_p (
    .clk(clk), .rst_n(rst_n), .wen(wen), .wmask(wmask), .waddr(waddr), .wdata(wdata),
    .wr_frame_end(wr_frame_end), .wr_ready(wr_ready_o[0]), .ren(ren), .raddr(raddr),
    .rd_frame_end(rd_frame_end), .rd_avail(rd_avail_o[0]), .rdata(rdata_o[0]),
    .rvalid(rvalid_o[0]), .err_oob(err_oob_o[0]), .err_wr_stall(err_stall_o[0]));

  maxpool_pingpong_buffer #(.N_CH(N_CH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .OFFSET(-1)) u_dut_m (
    .clk(clk), .rst_n(rst_n), .wen(wen), .wmask(wmask), .waddr(waddr), .wdata(wdata),
    .wr_frame_end(wr_frame_end), .wr_ready(wr_ready_o[1]), .ren(ren), .raddr(raddr),
    .rd_frame_end(rd_frame_end), .rd_avail(rd_avail_o[1]), .rdata(rdata_o[1]),
    .rvalid(rvalid_o[1]), .err_oob(err_oob_o[1]), .err_wr_stall(err_stall_o[1]));

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clamp(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  task automatic model_reset();
    full_m[0] = 0; full_m[1] = 0;
    wb_m = 0; rb_m = 0;
    eoob_m = 0; estall_m = 0;
    q0.delete(); q1.delete();
    exp_rv = 1'b0;
    last_v[0] = 0; last_v[1] = 0;
  endtask

  // One clock: check flags, predict the cycle's effect, clock it, queue read results.
  task automatic cycle();
    bit wrdy, ravl, fire;
    int a, d;
    int ev [2];
    wrdy = !full_m[wb_m];
    ravl = full_m[rb_m];
    for (int k = 0; k < 2; k++) begin
      check($sformatf("wr_ready[%0d]", k), int'(wr_ready_o[k]), int'(wrdy));
      check($sformatf("rd_avail[%0d]", k), int'(rd_avail_o[k]), int'(ravl));
      check($sformatf("err_oob[%0d]", k), int'(err_oob_o[k]), int'(eoob_m));
      check($sformatf("err_wr_stall[%0d]", k), int'(err_stall_o[k]), int'(estall_m));
    end
    fire = ren && ravl;
    ev[0] = 0; ev[1] = 0;
    if (fire) begin
      a = int'(raddr);
      for (int k = 0; k < 2; k++) begin
        if (a >= DEPTH) ev[k] = 0;
        else if (!written[rb_m][a]) ev[k] = UNK;
        else ev[k] = clamp(mem_m[rb_m][a] + offs[k]);
      end
    end
    for (int i = 0; i < N_CH; i++) begin
      if (wen && wmask[i]) begin
        a = int'(waddr[i*ADDR_W +: ADDR_W]);
        d = int'($signed(wdata[i*DATA_W +: DATA_W]));
        if (a >= DEPTH) eoob_m = 1;
        else if (wrdy) begin
          mem_m[wb_m][a] = d;
          written[wb_m][a] = 1;
        end
      end
    end
    if ((wen || wr_frame_end) && !wrdy) estall_m = 1;
    if (wr_frame_end && wrdy) begin full_m[wb_m] = 1; wb_m ^= 1; end
    if (rd_frame_end && ravl) begin full_m[rb_m] = 0; rb_m ^= 1; end
    @(posedge clk);
    exp_rv = fire;
    if (fire) begin
      q0.push_back(ev[0]);
      q1.push_back(ev[1]);
    end
    #1;
    wen = 0; wmask = '0; wr_frame_end = 0; ren = 0; rd_frame_end = 0;
  endtask

  task automatic do_write(input logic [N_CH-1:0] m, input int a0, input int d0,
                          input int a1, input int d1, input int a2, input int d2);
    wen = 1; wmask = m;
    waddr = {ADDR_W'(a2), ADDR_W'(a1), ADDR_W'(a0)};
    wdata = {DATA_W'(d2), DATA_W'(d1), DATA_W'(d0)};
    cycle();
  endtask

  task automatic do_read(input int a);
    ren = 1; raddr = ADDR_W'(a);
    cycle();
  endtask

  task automatic wr_end();
    wr_frame_end = 1;
    cycle();
  endtask

  task automatic rd_end();
    rd_frame_end = 1;
    cycle();
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("rvalid[%0d]", k), int'(rvalid_o[k]), int'(exp_rv));
        if (rvalid_o[k]) begin
          if ((k == 0 ? q0.size() : q1.size()) == 0) begin
            tests++; fails++;
            $display("FAIL rdata_unexpected[%0d]: rvalid=1, expected no pending read", k);
          end else begin
            int e;
            e = (k == 0) ? q0.pop_front() : q1.pop_front();
            if (e != UNK) check($sformatf("rdata[%0d]", k), int'($signed(rdata_o[k])), e);
            last_v[k] = e;
          end
        end else if (last_v[k] != UNK) begin
          check($sformatf("rdata_hold[%0d]", k), int'($signed(rdata_o[k])), last_v[k]);
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("reset_rvalid", int'(rvalid_o[k]), 0);
      check("reset_rdata", int'(rdata_o[k]), 0);
      check("reset_wr_ready", int'(wr_ready_o[k]), 1);
      check("reset_rd_avail", int'(rd_avail_o[k]), 0);
      check("reset_err_oob", int'(err_oob_o[k]), 0);
      check("reset_err_stall", int'(err_stall_o[k]), 0);
    end
    rst_n = 1;
    @(posedge clk); #1;

    // basic write / frame end / read, expect 6,7,8 through +1 offset
    do_write(3'b111, 0, 5, 1, 6, 2, 7);
    wr_end();
    check("t1_rd_avail", int'(rd_avail_o[0]), 1);
    do_read(0); do_read(1); do_read(2);
    cycle();
    rd_end();

    // lane collision, out-of-range lane, saturation corners
    do_write(3'b101, 10, 11, 600, 0, 10, 33);
    do_write(3'b111, 20, 44, 600, 55, 21, -5);
    do_write(3'b111, 30, 127, 31, -128, 32, 0);
    wr_end();
    check("t4_err_oob", int'(err_oob_o[0]), 1);
    do_read(10); do_read(20); do_read(21);
    do_read(30); do_read(31); do_read(32); do_read(600);
    cycle();
    rd_end();

    // both banks full: third write is stalled and dropped
    do_write(3'b001, 40, 1, 0, 0, 0, 0);
    wr_end();
    do_write(3'b001, 40, 2, 0, 0, 0, 0);
    wr_end();
    check("t2_wr_ready_low", int'(wr_ready_o[0]), 0);
    do_write(3'b001, 40, 99, 0, 0, 0, 0);
    wr_end();
    check("t2_err_stall", int'(err_stall_o[0]), 1);
    do_read(40);
    rd_end();
    check("t2_wr_ready_back", int'(wr_ready_o[0]), 1);
    do_read(40);

    // simultaneous writer and reader frame ends on different banks
    do_write(3'b001, 50, 17, 0, 0, 0, 0);
    wr_end();
    rd_end();
    do_write(3'b001, 50, -60, 0, 0, 0, 0);
    wr_frame_end = 1; rd_frame_end = 1;
    cycle();
    check("t5_rd_avail", int'(rd_avail_o[0]), 1);
    check("t5_wr_ready", int'(wr_ready_o[0]), 1);
    do_read(50);
    cycle();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      wen = 1'($urandom_range(0, 1));
      wmask = N_CH'($urandom);
      for (int i = 0; i < N_CH; i++) begin
        int a;
        a = ($urandom_range(0, 19) == 0) ? int'($urandom_range(DEPTH, 1023)) : int'($urandom_range(0, 15));
        waddr[i*ADDR_W +: ADDR_W] = ADDR_W'(a);
        wdata[i*DATA_W +: DATA_W] = DATA_W'($urandom);
      end
      wr_frame_end = ($urandom_range(0, 11) == 0);
      ren = 1'($urandom_range(0, 1));
      raddr = ($urandom_range(0, 19) == 0) ? ADDR_W'(600) : ADDR_W'($urandom_range(0, 15));
      rd_frame_end = ($urandom_range(0, 9) == 0);
      cycle();
    end

    // reset asserted while a read result is on the outputs
    for (int n = 0; n < 4; n++) begin
      if (full_m[rb_m]) break;
      if (!full_m[wb_m]) wr_frame_end = 1;
      else rd_frame_end = 1;
      cycle();
    end
    ren = 1; raddr = ADDR_W'(3);
    cycle();
    check("t6_pre_rvalid", int'(rvalid_o[0]), 1);
    rst_n = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("t6_rvalid", int'(rvalid_o[k]), 0);
      check("t6_rdata", int'(rdata_o[k]), 0);
      check("t6_rd_avail", int'(rd_avail_o[k]), 0);
      check("t6_wr_ready", int'(wr_ready_o[k]), 1);
    end
    model_reset();
    @(negedge clk); #2;
    rst_n = 1;
    @(posedge clk); #1;
    do_write(3'b010, 0, 0, 7, -100, 0, 0);
    wr_end();
    do_read(7);
    cycle();
    cycle();
    check("drain", q0.size() + q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
